// File: rtl/digitizer_sync_fifo.sv
// digitizer_sync_fifo: single-clock sample FIFO with standard or first-word-fall-through read,
// threshold flags, occupancy count, error pulses and synchronous flush.
module digitizer_sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH_LOG2 = 10,
  parameter int FWFT = 0,
  parameter int AFULL_TH = 1020,
  parameter int AEMPTY_TH = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FLUSH,
  input  logic [WIDTH-1:0]      DATA,
  input  logic                  WE,
  input  logic                  RE,
  output logic [WIDTH-1:0]      Q,
  output logic                  DVLD,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  AFULL,
  output logic                  AEMPTY,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  logic [WIDTH-1:0] ram [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [WIDTH-1:0] rd_word;
  logic rd_pend, wr_acc, rd_acc, ram_rd, dvld_nxt;
  logic [DEPTH_LOG2:0] count_nxt, ram_cnt;
  always_comb begin
    wr_acc = WE && !FULL;
    rd_acc = RE && !EMPTY;
    // in FWFT mode the output register holds one counted word that is no longer in RAM
    ram_cnt = COUNT - CW'(DVLD);
    ram_rd = (FWFT != 0) ? ((!DVLD || rd_acc) && ram_cnt != '0) : rd_acc;
    dvld_nxt = ram_rd || (DVLD && !rd_acc);
    count_nxt = (wr_acc && !rd_acc) ? COUNT + CW'(1) :
                (rd_acc && !wr_acc) ? COUNT - CW'(1) : COUNT;
  end
  always_ff @(posedge CLK)
    if (wr_acc && !FLUSH) ram[wptr] <= DATA;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      wptr <= '0;
      rptr <= '0;
      COUNT <= '0;
      FULL <= 1'b0;
      EMPTY <= 1'b1;
      AFULL <= 1'b0;
      AEMPTY <= 1'b1;
      OVERFLOW <= 1'b0;
      UNDERFLOW <= 1'b0;
      DVLD <= 1'b0;
      Q <= '0;
      rd_word <= '0;
      rd_pend <= 1'b0;
    end else if (FLUSH) begin
      wptr <= '0;
      rptr <= '0;
      COUNT <= '0;
      FULL <= 1'b0;
      EMPTY <= 1'b1;
      AFULL <= 1'b0;
      AEMPTY <= 1'b1;
      OVERFLOW <= 1'b0;
      UNDERFLOW <= 1'b0;
      DVLD <= 1'b0;
      rd_pend <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + DEPTH_LOG2'(1);
      if (ram_rd) rptr <= rptr + DEPTH_LOG2'(1);
      COUNT <= count_nxt;
      FULL <= count_nxt == CW'(DEPTH);
      AFULL <= count_nxt >= CW'(AFULL_TH);
      AEMPTY <= count_nxt <= CW'(AEMPTY_TH);
      OVERFLOW <= WE && FULL;
      UNDERFLOW <= RE && EMPTY;
      if (FWFT != 0) begin
        if (ram_rd) Q <= ram[rptr];
        DVLD <= dvld_nxt;
        EMPTY <= !dvld_nxt;
      end else begin
        // two-stage read: RAM word captured at the accepting edge, presented one edge later
        if (ram_rd) rd_word <= ram[rptr];
        rd_pend <= rd_acc;
        if (rd_pend) Q <= rd_word;
        DVLD <= rd_pend;
        EMPTY <= count_nxt == '0;
      end
    end
endmodule
